flow_controller: RTL and testbench
==================================

Name: flow_controller

Overview:
Parametrised program-flow controller for the core's instruction fetch path. It sits on the device/address/data write bus as the controller device and drives the instruction-register enable and the instruction pointer.
- Generalises the two-state reset/work controller with:
  - configurable data and address width;
  - latched compare operands and conditional jumps;
  - a timed wait state and a halt state;
  - a call/return stack of configurable depth with overflow/underflow detection.

Parameters:
DATA_WIDTH, 16, width of i_address and i_data, and of the compare operands
ADDR_WIDTH, 16, width of the instruction pointer and the jump target
STACK_DEPTH, 8, number of return-address entries (power of two, minimum 2)
DEV_WIDTH, 4, width of the device select
DEVICE_ID, 4'h1, i_device value that selects this block
RESET_VECTOR, 0, o_irp value held while in RST

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
i_device  in  DEV_WIDTH  device select; block is addressed when i_device==DEVICE_ID
i_address  in  DATA_WIDTH  port number (register select)
i_data  in  DATA_WIDTH  write data
i_wr  in  1  write strobe; bus write accepted on a clk edge with i_wr=1 and device match
i_step  in  1  fetch advance request from the core
o_ir_reg_en  out  2  00 idle, 01 reset, 10 work
o_irp  out  ADDR_WIDTH  instruction pointer
o_busy  out  1  high in WAIT
o_halted  out  1  high in HALT
o_stack_err  out  1  sticky overflow/underflow flag
o_depth  out  clog2(STACK_DEPTH)+1  current stack occupancy

Behaviour:
Port map (i_address value): 0 OPA, 1 OPB, 2 TARGET, 3 JUMP_DIRECT, 4 JUMP_LARGER, 5 JUMP_SMALLER, 6 JUMP_EQUAL, 7 JUMP_UNEQUAL, 8 WAIT, 9 STOP, 10 CALL, 11 RETURN. Other port values: write ignored.
- Reset: state=RST, o_irp=RESET_VECTOR, OPA=OPB=TARGET=0, stack empty, o_depth=0, o_stack_err=0, o_busy=0, o_halted=0, o_ir_reg_en=01, wait counter=0.
- Register writes (OPA, OPB, TARGET):
  - accepted in RST and RUN, one cycle.
  - TARGET takes i_data[ADDR_WIDTH-1:0], zero-extended if ADDR_WIDTH > DATA_WIDTH.
- States:
  - RST: o_ir_reg_en=01; i_step ignored. A write to JUMP_DIRECT sets o_irp<=TARGET and moves to RUN. All other control ports are ignored in RST.
  - RUN: o_ir_reg_en=10.
    - Each i_step: o_irp<=o_irp+1, wrapping modulo 2^ADDR_WIDTH.
    - A control-port write takes priority over i_step in the same cycle.
  - WAIT: o_ir_reg_en=00, o_busy=1, o_irp frozen.
    - Counter decrements each cycle; when the counter is 1, next state is RUN (dwell = N cycles).
    - All bus writes and i_step are ignored in WAIT.
  - HALT: o_ir_reg_en=00, o_halted=1, o_irp frozen. Exit only via rst_n.
- Jumps, applied at the clk edge of the write (o_irp updates one cycle after the write):
  - JUMP_DIRECT: always taken.
  - LARGER / SMALLER / EQUAL / UNEQUAL: taken if OPA>OPB / OPA<OPB / OPA==OPB / OPA!=OPB respectively. Compare is unsigned by default.
  - Not taken: o_irp unchanged (no implicit step).
  - The comparison uses the OPA/OPB values registered before the jump write.
- WAIT port: i_data==0 means no state change. Otherwise load counter=i_data and enter WAIT.
- STOP port: enter HALT next cycle.
- CALL:
  - Stack not full: push o_irp+1 (wrapped), o_irp<=TARGET, depth+1.
  - Stack full: no push, no jump, o_stack_err<=1.
- RETURN:
  - Stack not empty: pop top into o_irp, depth-1.
  - Stack empty: o_irp unchanged, o_stack_err<=1.
- o_stack_err stays set until reset.
- Reset asserted in any state (including mid-WAIT) returns the block to the full reset values on the next edge.

Optional Feature:
FLOW_SIGNED_CMP_EN: when defined, LARGER/SMALLER compare OPA and OPB as two's-complement signed DATA_WIDTH values. When undefined, the compare is unsigned. EQUAL/UNEQUAL are unaffected either way.

Test Plan:
- Reset, then 3 cycles of i_step -> o_irp stays 0 and o_ir_reg_en=01. Write TARGET=0x0010, then JUMP_DIRECT -> o_irp=0x0010, o_ir_reg_en=10. Then 2 i_step -> o_irp=0x0012.
- In RUN write OPA=5, OPB=3, TARGET=0x40, then JUMP_LARGER -> o_irp=0x40. Then JUMP_SMALLER -> o_irp stays 0x40. Write OPA=0xFFFF, OPB=1, JUMP_LARGER -> taken without the macro; with FLOW_SIGNED_CMP_EN not taken.
- WAIT with i_data=4 -> o_busy=1 and o_ir_reg_en=00 for exactly 4 cycles, i_step and writes ignored during them, then RUN. WAIT with i_data=0 -> no state change.
- STACK_DEPTH=2: CALL at o_irp=0x10 (TARGET=0x20), then CALL at 0x20 (TARGET=0x30) -> depth=2, o_irp=0x30. Third CALL -> o_stack_err=1, o_irp stays 0x30. RETURN twice -> o_irp 0x21 then 0x11. Third RETURN -> o_irp unchanged, error stays set.
- o_irp=0xFFFF with i_step -> o_irp wraps to 0x0000.
- STOP -> o_halted=1, writes and steps ignored. rst_n low during HALT, and again mid-WAIT -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/flow_controller.sv
// Program-flow controller: drives instruction-register enable and instruction pointer from bus writes.
// Optional macro FLOW_SIGNED_CMP_EN makes JUMP_LARGER/JUMP_SMALLER compare operands as signed.
module flow_controller #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned DEV_WIDTH   = 4,
  parameter logic [DEV_WIDTH-1:0]  DEVICE_ID    = DEV_WIDTH'(1),
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DEV_WIDTH-1:0]          i_device,
  input  logic [DATA_WIDTH-1:0]         i_address,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic                          i_wr,
  input  logic                          i_step,
  output logic [1:0]                    o_ir_reg_en,
  output logic [ADDR_WIDTH-1:0]         o_irp,
  output logic                          o_busy,
  output logic                          o_halted,
  output logic                          o_stack_err,
  output logic [$clog2(STACK_DEPTH):0]  o_depth
);

  localparam int unsigned PTR_W   = $clog2(STACK_DEPTH);
  localparam int unsigned DEPTH_W = PTR_W + 1;

  localparam logic [3:0] P_OPA      = 4'd0;
  localparam logic [3:0] P_OPB      = 4'd1;
  localparam logic [3:0] P_TARGET   = 4'd2;
  localparam logic [3:0] P_JUMP     = 4'd3;
  localparam logic [3:0] P_LARGER   = 4'd4;
  localparam logic [3:0] P_SMALLER  = 4'd5;
  localparam logic [3:0] P_EQUAL    = 4'd6;
  localparam logic [3:0] P_UNEQUAL  = 4'd7;
  localparam logic [3:0] P_WAIT     = 4'd8;
  localparam logic [3:0] P_STOP     = 4'd9;
  localparam logic [3:0] P_CALL     = 4'd10;
  localparam logic [3:0] P_RETURN   = 4'd11;

  typedef enum logic [1:0] {ST_RST, ST_RUN, ST_WAIT, ST_HALT} state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  opa, opb, wait_cnt;
  logic [ADDR_WIDTH-1:0]  target;
  logic [ADDR_WIDTH-1:0]  stack [STACK_DEPTH];

  logic [3:0]             port;
  logic                   wr_hit;
  logic [ADDR_WIDTH-1:0]  target_in, irp_inc, stack_top;
  logic [PTR_W-1:0]       top_idx;
  logic                   larger, smaller, taken, full, empty, push;

  assign port      = i_address[3:0];
  assign wr_hit    = i_wr && (i_device == DEVICE_ID) && (i_address < DATA_WIDTH'(12));
  assign target_in = ADDR_WIDTH'(i_data);
  assign irp_inc   = o_irp + ADDR_WIDTH'(1);

`ifdef FLOW_SIGNED_CMP_EN
  assign larger  = $signed(opa) > $signed(opb);
  assign smaller = $signed(opa) < $signed(opb);
`else
  assign larger  = opa > opb;
  assign smaller = opa < opb;
`endif

  always_comb begin
    taken = 1'b0;
    case (port)
      P_JUMP:    taken = 1'b1;
      P_LARGER:  taken = larger;
      P_SMALLER: taken = smaller;
      P_EQUAL:   taken = (opa == opb);
      P_UNEQUAL: taken = (opa != opb);
      default:   taken = 1'b0;
    endcase
  end

  // Full depth has zero low bits, so low-bits-minus-one still lands on the top entry.
  assign full      = (o_depth == DEPTH_W'(STACK_DEPTH));
  assign empty     = (o_depth == '0);
  assign top_idx   = o_depth[PTR_W-1:0] - PTR_W'(1);
  assign stack_top = stack[top_idx];
  assign push      = rst_n && (state == ST_RUN) && wr_hit && (port == P_CALL) && !full;

  always_ff @(posedge clk) begin
    if (push)
      stack[o_depth[PTR_W-1:0]] <= irp_inc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_RST;
      o_ir_reg_en <= 2'b01;
      o_irp       <= RESET_VECTOR;
      o_busy      <= 1'b0;
      o_halted    <= 1'b0;
      o_stack_err <= 1'b0;
      o_depth     <= '0;
      opa         <= '0;
      opb         <= '0;
      target      <= '0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        ST_RST: begin
          if (wr_hit) begin
            case (port)
              P_OPA:    opa    <= i_data;
              P_OPB:    opb    <= i_data;
              P_TARGET: target <= target_in;
              P_JUMP: begin
                o_irp       <= target;
                state       <= ST_RUN;
                o_ir_reg_en <= 2'b10;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (wr_hit) begin
            case (port)
              // Operand/target writes are not control writes, so a step in the same cycle still applies.
              P_OPA, P_OPB, P_TARGET: begin
                if (port == P_OPA) opa <= i_data;
                if (port == P_OPB) opb <= i_data;
                if (port == P_TARGET) target <= target_in;
                if (i_step) o_irp <= irp_inc;
              end
              P_JUMP, P_LARGER, P_SMALLER, P_EQUAL, P_UNEQUAL: begin
                if (taken) o_irp <= target;
              end
              P_WAIT: begin
                if (i_data != '0) begin
                  wait_cnt    <= i_data;
                  state       <= ST_WAIT;
                  o_ir_reg_en <= 2'b00;
                  o_busy      <= 1'b1;
                end
              end
              P_STOP: begin
                state       <= ST_HALT;
                o_ir_reg_en <= 2'b00;
                o_halted    <= 1'b1;
              end
              P_CALL: begin
                if (!full) begin
                  o_irp   <= target;
                  o_depth <= o_depth + DEPTH_W'(1);
                end else begin
                  o_stack_err <= 1'b1;
                end
              end
              P_RETURN: begin
                if (!empty) begin
                  o_irp   <= stack_top;
                  o_depth <= o_depth - DEPTH_W'(1);
                end else begin
                  o_stack_err <= 1'b1;
                end
              end
              default: ;
            endcase
          end else if (i_step) begin
            o_irp <= irp_inc;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - DATA_WIDTH'(1);
          if (wait_cnt == DATA_WIDTH'(1)) begin
            state       <= ST_RUN;
            o_ir_reg_en <= 2'b10;
            o_busy      <= 1'b0;
          end
        end
        ST_HALT: ;
        default: state <= ST_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_flow_controller.sv
// Self-checking bench for flow_controller: vector table driven through an expectation queue,
// plus hand sequences for WAIT dwell, reset mid-WAIT and HALT.
module tb_flow_controller;

  localparam logic [15:0] P_OPA = 16'd0, P_OPB = 16'd1, P_TGT = 16'd2, P_JD = 16'd3;
  localparam logic [15:0] P_JL = 16'd4, P_JS = 16'd5, P_JEQ = 16'd6, P_JNE = 16'd7;
  localparam logic [15:0] P_WAIT = 16'd8, P_STOP = 16'd9, P_CALL = 16'd10, P_RET = 16'd11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  device;
  logic [15:0] address, data;
  logic        wr, step;
  logic [1:0]  ir_reg_en;
  logic [15:0] irp;
  logic        busy, halted, stack_err;
  logic [1:0]  depth;

  always #5 clk = ~clk;

  flow_controller #(
    .DATA_WIDTH  (16),
    .ADDR_WIDTH  (16),
    .STACK_DEPTH (2),
    .DEV_WIDTH   (4),
    .DEVICE_ID   (4'h1),
    .RESET_VECTOR(16'h0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_device   (device),
    .i_address  (address),
    .i_data     (data),
    .i_wr       (wr),
    .i_step     (step),
    .o_ir_reg_en(ir_reg_en),
    .o_irp      (irp),
    .o_busy     (busy),
    .o_halted   (halted),
    .o_stack_err(stack_err),
    .o_depth    (depth)
  );

  typedef struct {
    string       name;
    logic        rst_n;
    logic [3:0]  dev;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic        step;
    logic [1:0]  en;
    logic [15:0] irp;
    logic        busy;
    logic        halted;
    logic        err;
    logic [1:0]  depth;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(string name, logic r, logic w, logic [15:0] a, logic [15:0] d,
                              logic s, logic [1:0] en, logic [15:0] ip, logic b, logic h,
                              logic e, logic [1:0] dp);
    vec_t v;
    v.name = name; v.rst_n = r; v.dev = 4'h1; v.wr = w; v.addr = a; v.data = d; v.step = s;
    v.en = en; v.irp = ip; v.busy = b; v.halted = h; v.err = e; v.depth = dp;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Drive at the falling edge, record the expectation, compare 1 time unit after the rising edge.
  task automatic apply(vec_t v);
    vec_t e;
    rst_n = v.rst_n; device = v.dev; wr = v.wr; address = v.addr; data = v.data; step = v.step;
    exp_q.push_back(v);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk({e.name, ".en"},     32'(ir_reg_en), 32'(e.en));
    chk({e.name, ".irp"},    32'(irp),       32'(e.irp));
    chk({e.name, ".busy"},   32'(busy),      32'(e.busy));
    chk({e.name, ".halted"}, 32'(halted),    32'(e.halted));
    chk({e.name, ".err"},    32'(stack_err), 32'(e.err));
    chk({e.name, ".depth"},  32'(depth),     32'(e.depth));
    @(negedge clk);
  endtask

  initial begin
    vec_t wv;
    logic [15:0] signed_jl_irp;
    int n;

`ifdef FLOW_SIGNED_CMP_EN
    signed_jl_irp = 16'h0051;
`else
    signed_jl_irp = 16'h0060;
`endif

    //               name          rst wr addr    data      stp en    irp       bsy hlt err dep
    vecs.push_back(mk("reset",      0, 0, 16'd0,  16'h0000, 0, 2'b01, 16'h0000, 0, 0, 0, 2'd0));
    vecs.push_back(mk("rst_step0",  1, 0, 16'd0,  16'h0000, 1, 2'b01, 16'h0000, 0, 0, 0, 2'd0));
    vecs.push_back(mk("rst_step1",  1, 0, 16'd0,  16'h0000, 1, 2'b01, 16'h0000, 0, 0, 0, 2'd0));
    vecs.push_back(mk("rst_step2",  1, 0, 16'd0,  16'h0000, 1, 2'b01, 16'h0000, 0, 0, 0, 2'd0));
    vecs.push_back(mk("rst_call",   1, 1, P_CALL, 16'h0000, 0, 2'b01, 16'h0000, 0, 0, 0, 2'd0));
    vecs.push_back(mk("tgt_10",     1, 1, P_TGT,  16'h0010, 0, 2'b01, 16'h0000, 0, 0, 0, 2'd0));
    vecs.push_back(mk("jd_10",      1, 1, P_JD,   16'h0000, 0, 2'b10, 16'h0010, 0, 0, 0, 2'd0));
    vecs.push_back(mk("step_11",    1, 0, 16'd0,  16'h0000, 1, 2'b10, 16'h0011, 0, 0, 0, 2'd0));
    vecs.push_back(mk("step_12",    1, 0, 16'd0,  16'h0000, 1, 2'b10, 16'h0012, 0, 0, 0, 2'd0));
    vecs.push_back(mk("opa_5",      1, 1, P_OPA,  16'h0005, 0, 2'b10, 16'h0012, 0, 0, 0, 2'd0));
    vecs.push_back(mk("opb_3",      1, 1, P_OPB,  16'h0003, 0, 2'b10, 16'h0012, 0, 0, 0, 2'd0));
    vecs.push_back(mk("tgt_40",     1, 1, P_TGT,  16'h0040, 0, 2'b10, 16'h0012, 0, 0, 0, 2'd0));
    vecs.push_back(mk("jl_taken",   1, 1, P_JL,   16'h0000, 0, 2'b10, 16'h0040, 0, 0, 0, 2'd0));
    vecs.push_back(mk("js_not",     1, 1, P_JS,   16'h0000, 0, 2'b10, 16'h0040, 0, 0, 0, 2'd0));
    vecs.push_back(mk("tgt_50",     1, 1, P_TGT,  16'h0050, 0, 2'b10, 16'h0040, 0, 0, 0, 2'd0));
    vecs.push_back(mk("jne_taken",  1, 1, P_JNE,  16'h0000, 1, 2'b10, 16'h0050, 0, 0, 0, 2'd0));
    vecs.push_back(mk("jeq_prio",   1, 1, P_JEQ,  16'h0000, 1, 2'b10, 16'h0050, 0, 0, 0, 2'd0));
    vecs.push_back(mk("tgt_60",     1, 1, P_TGT,  16'h0060, 0, 2'b10, 16'h0050, 0, 0, 0, 2'd0));
    wv = mk("wrong_dev",            1, 1, P_JD,   16'h0000, 0, 2'b10, 16'h0050, 0, 0, 0, 2'd0);
    wv.dev = 4'h2;
    vecs.push_back(wv);
    vecs.push_back(mk("bad_port",   1, 1, 16'd12, 16'h0000, 1, 2'b10, 16'h0051, 0, 0, 0, 2'd0));
    vecs.push_back(mk("opa_ffff",   1, 1, P_OPA,  16'hFFFF, 0, 2'b10, 16'h0051, 0, 0, 0, 2'd0));
    vecs.push_back(mk("opb_1",      1, 1, P_OPB,  16'h0001, 0, 2'b10, 16'h0051, 0, 0, 0, 2'd0));
    vecs.push_back(mk("jl_sign",    1, 1, P_JL,   16'h0000, 0, 2'b10, signed_jl_irp, 0, 0, 0, 2'd0));
    vecs.push_back(mk("jd_60",      1, 1, P_JD,   16'h0000, 0, 2'b10, 16'h0060, 0, 0, 0, 2'd0));
    vecs.push_back(mk("tgt_ffff",   1, 1, P_TGT,  16'hFFFF, 0, 2'b10, 16'h0060, 0, 0, 0, 2'd0));
    vecs.push_back(mk("jd_ffff",    1, 1, P_JD,   16'h0000, 0, 2'b10, 16'hFFFF, 0, 0, 0, 2'd0));
    vecs.push_back(mk("step_wrap",  1, 0, 16'd0,  16'h0000, 1, 2'b10, 16'h0000, 0, 0, 0, 2'd0));
    vecs.push_back(mk("tgt_10b",    1, 1, P_TGT,  16'h0010, 0, 2'b10, 16'h0000, 0, 0, 0, 2'd0));
    vecs.push_back(mk("jd_10b",     1, 1, P_JD,   16'h0000, 0, 2'b10, 16'h0010, 0, 0, 0, 2'd0));
    vecs.push_back(mk("tgt_20",     1, 1, P_TGT,  16'h0020, 0, 2'b10, 16'h0010, 0, 0, 0, 2'd0));
    vecs.push_back(mk("call_1",     1, 1, P_CALL, 16'h0000, 0, 2'b10, 16'h0020, 0, 0, 0, 2'd1));
    vecs.push_back(mk("tgt_30",     1, 1, P_TGT,  16'h0030, 0, 2'b10, 16'h0020, 0, 0, 0, 2'd1));
    vecs.push_back(mk("call_2",     1, 1, P_CALL, 16'h0000, 0, 2'b10, 16'h0030, 0, 0, 0, 2'd2));
    vecs.push_back(mk("call_ovf",   1, 1, P_CALL, 16'h0000, 0, 2'b10, 16'h0030, 0, 0, 1, 2'd2));
    vecs.push_back(mk("ret_1",      1, 1, P_RET,  16'h0000, 0, 2'b10, 16'h0021, 0, 0, 1, 2'd1));
    vecs.push_back(mk("ret_2",      1, 1, P_RET,  16'h0000, 0, 2'b10, 16'h0011, 0, 0, 1, 2'd0));
    vecs.push_back(mk("ret_udf",    1, 1, P_RET,  16'h0000, 0, 2'b10, 16'h0011, 0, 0, 1, 2'd0));
    vecs.push_back(mk("wait_0",     1, 1, P_WAIT, 16'h0000, 0, 2'b10, 16'h0011, 0, 0, 1, 2'd0));
    vecs.push_back(mk("wait_4",     1, 1, P_WAIT, 16'h0004, 0, 2'b00, 16'h0011, 1, 0, 1, 2'd0));
    vecs.push_back(mk("wait_c2",    1, 1, P_JD,   16'h0000, 1, 2'b00, 16'h0011, 1, 0, 1, 2'd0));
    vecs.push_back(mk("wait_c3",    1, 1, P_JD,   16'h0000, 1, 2'b00, 16'h0011, 1, 0, 1, 2'd0));
    vecs.push_back(mk("wait_c4",    1, 1, P_JD,   16'h0000, 1, 2'b00, 16'h0011, 1, 0, 1, 2'd0));
    vecs.push_back(mk("wait_exit",  1, 1, P_JD,   16'h0000, 1, 2'b10, 16'h0011, 0, 0, 1, 2'd0));
    vecs.push_back(mk("post_wait",  1, 0, 16'd0,  16'h0000, 1, 2'b10, 16'h0012, 0, 0, 1, 2'd0));

    rst_n = 1'b0; device = 4'h1; wr = 1'b0; address = '0; data = '0; step = 1'b0;
    @(negedge clk);
    foreach (vecs[i]) apply(vecs[i]);

    // WAIT dwell measured by counting busy cycles, bounded in case busy never drops.
    wr = 1'b1; address = P_WAIT; data = 16'd5; step = 1'b0;
    @(posedge clk); #1;
    wr = 1'b0; step = 1'b1;
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    chk("wait5_dwell", 32'(n), 32'd5);
    chk("wait5_irp", 32'(irp), 32'h0012);
    step = 1'b0;
    @(negedge clk);

    // Reset mid-WAIT.
    apply(mk("wait_10",   1, 1, P_WAIT, 16'h000A, 0, 2'b00, 16'h0012, 1, 0, 1, 2'd0));
    apply(mk("wait_hold", 1, 0, 16'd0,  16'h0000, 1, 2'b00, 16'h0012, 1, 0, 1, 2'd0));
    apply(mk("wait_rst",  0, 0, 16'd0,  16'h0000, 0, 2'b01, 16'h0000, 0, 0, 0, 2'd0));
    apply(mk("wait_rst2", 1, 0, 16'd0,  16'h0000, 0, 2'b01, 16'h0000, 0, 0, 0, 2'd0));

    // HALT: entered by STOP, everything ignored until reset.
    apply(mk("h_tgt7",    1, 1, P_TGT,  16'h0007, 0, 2'b01, 16'h0000, 0, 0, 0, 2'd0));
    apply(mk("h_jd7",     1, 1, P_JD,   16'h0000, 0, 2'b10, 16'h0007, 0, 0, 0, 2'd0));
    apply(mk("h_stop",    1, 1, P_STOP, 16'h0000, 0, 2'b00, 16'h0007, 0, 1, 0, 2'd0));
    apply(mk("h_jd",      1, 1, P_JD,   16'h0000, 1, 2'b00, 16'h0007, 0, 1, 0, 2'd0));
    apply(mk("h_call",    1, 1, P_CALL, 16'h0000, 1, 2'b00, 16'h0007, 0, 1, 0, 2'd0));
    apply(mk("h_step",    1, 0, 16'd0,  16'h0000, 1, 2'b00, 16'h0007, 0, 1, 0, 2'd0));
    apply(mk("h_rst",     0, 0, 16'd0,  16'h0000, 0, 2'b01, 16'h0000, 0, 0, 0, 2'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
